// File: rtl/route_executor.sv
`default_nettype none
// ============================================================================
// Module   : route_executor
// Purpose  : Sequences one interlocking route: drives both throat points with
//            single coil pulses, settles, clears the signal, releases on pass.
// Revision : 1.0 - initial release
// ============================================================================
module route_executor #(
    parameter int unsigned PULSE_CYCLES  = 5_000_000,
    parameter int unsigned SETTLE_CYCLES = 2_500_000,
    parameter int unsigned CNT_W         = 23
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_side,
    input  logic [1:0] cmd_track,
    input  logic       cancel,
    input  logic [3:0] occupied,
    output logic [3:0] coil_normal,
    output logic [3:0] coil_reverse,
    output logic [3:0] point_pos,
    output logic [7:0] signal_clear,
    output logic       busy,
    output logic       reject
);

    localparam logic [CNT_W-1:0] c_pulse_load  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE_A = 3'd1,
        S_DRIVE_B = 3'd2,
        S_SETTLE  = 3'd3,
        S_CLEAR   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_reject;
    logic             r_side;
    logic [1:0]       r_track;
    logic             r_pulsing;
    logic             r_pulsed;
    logic [CNT_W-1:0] r_timer;
    logic [3:0]       r_coil_normal;
    logic [3:0]       r_coil_reverse;
    logic [3:0]       r_point_pos;
    logic [7:0]       r_signal;

    // Point under control in the current drive state and its wanted position.
    logic [1:0] w_pt;
    logic       w_target;
    logic       w_in_b;

    assign w_in_b   = (r_state == S_DRIVE_B);
    assign w_pt     = {r_side, w_in_b};
    assign w_target = w_in_b ? r_track[0] : r_track[1];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= S_IDLE;
            r_ready        <= 1'b1;
            r_reject       <= 1'b0;
            r_side         <= 1'b0;
            r_track        <= 2'd0;
            r_pulsing      <= 1'b0;
            r_pulsed       <= 1'b0;
            r_timer        <= '0;
            r_coil_normal  <= 4'd0;
            r_coil_reverse <= 4'd0;
            r_point_pos    <= 4'd0;
            r_signal       <= 8'd0;
        end else begin
            r_reject <= 1'b0;
            if (cancel && (r_state != S_IDLE)) begin
                // Abort wins over everything; an unfinished pulse leaves point_pos as is.
                r_state        <= S_IDLE;
                r_ready        <= 1'b1;
                r_pulsing      <= 1'b0;
                r_coil_normal  <= 4'd0;
                r_coil_reverse <= 4'd0;
                r_signal       <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_valid && r_ready) begin
                            if (occupied[cmd_track]) begin
                                r_reject <= 1'b1;
                            end else begin
                                r_side    <= cmd_side;
                                r_track   <= cmd_track;
                                r_pulsed  <= 1'b0;
                                r_pulsing <= 1'b0;
                                r_ready   <= 1'b0;
                                r_state   <= S_DRIVE_A;
                            end
                        end
                    end

                    S_DRIVE_A, S_DRIVE_B: begin
                        if (r_pulsing) begin
                            if (r_timer == '0) begin
                                r_coil_normal       <= 4'd0;
                                r_coil_reverse      <= 4'd0;
                                r_point_pos[w_pt]   <= w_target;
                                r_pulsing           <= 1'b0;
                                if (w_in_b) begin
                                    r_timer <= c_settle_load;
                                    r_state <= S_SETTLE;
                                end else begin
                                    r_state <= S_DRIVE_B;
                                end
                            end else begin
                                r_timer <= r_timer - 1'b1;
                            end
                        end else if (r_point_pos[w_pt] == w_target) begin
                            if (!w_in_b) begin
                                r_state <= S_DRIVE_B;
                            end else if (r_pulsed) begin
                                r_timer <= c_settle_load;
                                r_state <= S_SETTLE;
                            end else begin
                                r_signal[{r_side, r_track}] <= 1'b1;
                                r_state                     <= S_CLEAR;
                            end
                        end else begin
                            if (w_target) begin
                                r_coil_reverse[w_pt] <= 1'b1;
                            end else begin
                                r_coil_normal[w_pt]  <= 1'b1;
                            end
                            r_timer   <= c_pulse_load;
                            r_pulsing <= 1'b1;
                            r_pulsed  <= 1'b1;
                        end
                    end

                    S_SETTLE: begin
                        if (r_timer == '0) begin
                            r_signal[{r_side, r_track}] <= 1'b1;
                            r_state                     <= S_CLEAR;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end

                    S_CLEAR: begin
                        if (occupied[r_track]) begin
                            r_signal <= 8'd0;
                            r_state  <= S_RELEASE;
                        end
                    end

                    S_RELEASE: begin
                        if (!occupied[r_track]) begin
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end

                    default: begin
                        r_state        <= S_IDLE;
                        r_ready        <= 1'b1;
                        r_pulsing      <= 1'b0;
                        r_coil_normal  <= 4'd0;
                        r_coil_reverse <= 4'd0;
                        r_signal       <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign cmd_ready    = r_ready;
    assign busy         = ~r_ready;
    assign reject       = r_reject;
    assign coil_normal  = r_coil_normal;
    assign coil_reverse = r_coil_reverse;
    assign point_pos    = r_point_pos;
    assign signal_clear = r_signal;

endmodule
`default_nettype wire
